wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage and architectural register file. Consumes the MEM/WB pipeline
//  register outputs and selects write-back data (memory vs ALU). Commits writes to a
//  2-read/1-write register file. Serves the ID stage with write-through bypass.
//  After reset, a sequencer clears the array one entry per cycle before accepting writes.
// PARAMETERS
//  NUM_REGS    32  number of architectural registers (entry 0 hardwired to zero)
//  DATA_W      32  register/data width in bits
//  ADDR_W      5   register address width; NUM_REGS == 2**ADDR_W
//  INIT_VALUE  0   value written to entries 1..NUM_REGS-1 during the init sweep
// PORTS
//  clk         in   1       clock; all state updates on posedge clk
//  rst         in   1       synchronous, active-high reset
//  ALUResult   in   DATA_W  ALU result from MEM/WB
//  Mem_r_data  in   DATA_W  load data from MEM/WB
//  RdAddr      in   ADDR_W  destination register from MEM/WB
//  Mem2Reg     in   1       1: write back Mem_r_data; 0: write back ALUResult
//  RegWrite    in   1       write-back enable from MEM/WB
//  RsAddr      in   ADDR_W  read port A address (ID stage)
//  RtAddr      in   ADDR_W  read port B address (ID stage)
//  RsData      out  DATA_W  read port A data, combinational
//  RtData      out  DATA_W  read port B data, combinational
//  WB_data     out  DATA_W  selected write-back value, for the forwarding unit
//  ready       out  1       1 = init sweep complete, writes accepted
//  wr_count    out  32      committed-write counter (only with WB_WRCOUNT_EN)
// BEHAVIOUR
//  - WB_data = Mem2Reg ? Mem_r_data : ALUResult. Pure combinational; valid in all states.
//  - States: INIT, RUN. Implementation uses a state flop plus an ADDR_W-bit init_idx.
//  - rst=1 at posedge: state<=INIT, init_idx<=1, ready<=0 (wr_count<=0). No array write.
//  - INIT, per posedge with rst=0: reg[init_idx]<=INIT_VALUE, then init_idx<=init_idx+1.
//    At the posedge that writes index NUM_REGS-1: state<=RUN, ready<=1.
//  - ready is therefore first high after the (NUM_REGS-1)th posedge following reset
//    release (31 cycles at defaults).
//  - INIT: RegWrite is ignored and the MEM/WB write is dropped, not queued.
//    RsData = RtData = 0.
//  - RUN, at posedge: if RegWrite && RdAddr!=0 then reg[RdAddr]<=WB_data.
//    RdAddr==0 writes are discarded.
//  - Read port (A shown; B identical with RtAddr):
//      RsAddr==0                                   -> 0
//      else ready && RegWrite && RdAddr==RsAddr    -> WB_data (same-cycle bypass)
//      else                                        -> reg[RsAddr]
//  - Both ports may hit the same address and/or the bypass simultaneously. Each port
//    resolves independently.
//  - Entry 0 is never stored. It reads 0 regardless of INIT_VALUE.
//  - Reset during RUN: in-flight write on that edge is dropped and INIT restarts from
//    index 1. Contents are overwritten by the sweep.
//  - Reset during INIT: init_idx returns to 1 and the sweep restarts.
//  - No X propagation: every array entry is defined after the sweep.
// CONFIGURATION
//  WB_WRCOUNT_EN defined:
//    - wr_count port exists.
//    - Reset value is 0.
//    - Increments by 1 on each committed RUN write (RegWrite && RdAddr!=0 && ready).
//    - Init-sweep writes and dropped writes are not counted.
//    - Wraps 32'hFFFFFFFF -> 0.
//  WB_WRCOUNT_EN undefined: wr_count port and counter are absent. All other behaviour
//    is identical.
// TESTING
//  1. rst 1 cycle, then hold RegWrite=1, RdAddr=5, ALUResult=32'hDEAD:
//     - ready=0 and RsData=0 for 31 posedges; ready=1 after the 31st.
//     - reg5 stays INIT_VALUE until the first RUN posedge, then reads 32'hDEAD.
//  2. RUN, Mem2Reg=1, Mem_r_data=32'h1234, ALUResult=32'h5678, RdAddr=7, RegWrite=1,
//     RsAddr=7: WB_data=32'h1234 and RsData=32'h1234 in the same cycle (bypass);
//     after the posedge, with RegWrite=0, RsData=32'h1234.
//  3. RUN, RegWrite=1, RdAddr=0, ALUResult=32'hFFFF_FFFF, RsAddr=RtAddr=0:
//     RsData=RtData=0 before and after the edge; wr_count unchanged.
//  4. RUN, write reg3=32'hA5A5 then reg4=32'h5A5A; RsAddr=3, RtAddr=4 -> 32'hA5A5,
//     32'h5A5A. Then RegWrite=1, RdAddr=3, ALUResult=1 with RsAddr=RtAddr=3:
//     both ports read 1 combinationally.
//  5. RUN, reg9=32'h77; assert rst for 1 cycle while RegWrite=1, RdAddr=9, data=32'h88:
//     ready drops; after the sweep reg9 reads INIT_VALUE (not 32'h88); wr_count=0.
//  6. WB_WRCOUNT_EN, preload wr_count=32'hFFFF_FFFE via force, then two committed writes
//     -> 32'hFFFF_FFFF then 0. Build without the macro: the bench compiles without
//     the wr_count connection.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back and ID read-port bundle for wb_regfile
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] Mem_r_data;
    logic [ADDR_W-1:0] RdAddr;
    logic              Mem2Reg;
    logic              RegWrite;
    logic [ADDR_W-1:0] RsAddr;
    logic [ADDR_W-1:0] RtAddr;
    logic [DATA_W-1:0] RsData;
    logic [DATA_W-1:0] RtData;
    logic [DATA_W-1:0] WB_data;
    logic              ready;

    modport master (
        output ALUResult, Mem_r_data, RdAddr, Mem2Reg, RegWrite, RsAddr, RtAddr,
        input  RsData, RtData, WB_data, ready
    );

    modport slave (
        input  ALUResult, Mem_r_data, RdAddr, Mem2Reg, RegWrite, RsAddr, RtAddr,
        output RsData, RtData, WB_data, ready
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 2R/1W register file with bypass and init sweep
// Optional committed-write counter on port wr_count when WB_WRCOUNT_EN is defined.
module wb_regfile #(
    parameter int                NUM_REGS   = 32,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WB_WRCOUNT_EN
    wb_regfile_if.slave bus,
    output logic [31:0] wr_count
`else
    wb_regfile_if.slave bus
`endif
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_idx_q, init_idx_d;
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] wb_data;
    logic              ready;
    logic              commit;
    logic              hit_rs, hit_rt;

    assign wb_data = bus.Mem2Reg ? bus.Mem_r_data : bus.ALUResult;
    assign ready   = (state_q == ST_RUN);
    assign commit  = ready && bus.RegWrite && (bus.RdAddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= ADDR_W'(1);
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + ADDR_W'(1);
                if (init_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Entry 0 has no storage; the sweep starts at 1 and writes to RdAddr 0 are gated off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                regs_q[init_idx_q] <= INIT_VALUE;
            end else if (commit) begin
                regs_q[bus.RdAddr] <= wb_data;
            end
        end
    end

    assign hit_rs = ready && bus.RegWrite && (bus.RdAddr == bus.RsAddr);
    assign hit_rt = ready && bus.RegWrite && (bus.RdAddr == bus.RtAddr);

    assign bus.RsData  = (bus.RsAddr == '0) ? '0 :
                         !ready             ? '0 :
                         hit_rs             ? wb_data : regs_q[bus.RsAddr];
    assign bus.RtData  = (bus.RtAddr == '0) ? '0 :
                         !ready             ? '0 :
                         hit_rt             ? wb_data : regs_q[bus.RtAddr];
    assign bus.WB_data = wb_data;
    assign bus.ready   = ready;

`ifdef WB_WRCOUNT_EN
    logic [31:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
        end else if (commit) begin
            wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (init sweep, bypass, reset, counter)
module tb_wb_regfile;
    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          NR    = 32;
    localparam logic [31:0] INITV = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef WB_WRCOUNT_EN
    logic [31:0] wr_count;
    wb_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .INIT_VALUE(INITV)) dut (
        .clk(clk), .rst(rst), .bus(bus), .wr_count(wr_count)
    );
`else
    wb_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .INIT_VALUE(INITV)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] mdl [0:NR-1];
    logic [31:0] exp_cnt;

    task automatic idle();
        bus.RegWrite   = 1'b0;
        bus.Mem2Reg    = 1'b0;
        bus.RdAddr     = '0;
        bus.ALUResult  = '0;
        bus.Mem_r_data = '0;
        bus.RsAddr     = '0;
        bus.RtAddr     = '0;
    endtask

    // Drives one write at a negedge, commits it on the next posedge, updates the model.
    task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
        bus.RegWrite  = 1'b1;
        bus.Mem2Reg   = 1'b0;
        bus.RdAddr    = a;
        bus.ALUResult = d;
        @(posedge clk);
        @(negedge clk);
        bus.RegWrite = 1'b0;
        if (a != 0) begin
            mdl[a]  = d;
            exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.RdAddr    = 5'd5;
        bus.ALUResult = 32'hDEAD;
        bus.RsAddr    = 5'd5;
        bus.RtAddr    = 5'd5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR - 1; i++) begin
            checks++;
            if (bus.ready !== 1'b0 || bus.RsData !== 32'h0 || bus.RtData !== 32'h0) begin
                errors++;
                $display("FAIL init_hold edge=%0d ready=%b rs=%h rt=%h want ready=0 rs=0 rt=0",
                         i, bus.ready, bus.RsData, bus.RtData);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise got=%b want=1", bus.ready);
        end
        for (int i = 1; i < NR; i++) mdl[i] = INITV;
        mdl[0] = 32'h0;
        exp_cnt = 32'h0;
        bus.RegWrite = 1'b0;
        exp_q.push_back(INITV);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL reg5_before_run got=%h want=%h", bus.RsData, exp_v);
        end
        bus.RegWrite = 1'b1;
        exp_q.push_back(32'hDEAD);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL reg5_bypass got=%h want=%h", bus.RsData, exp_v);
        end
        @(negedge clk);
        write_reg(5'd5, 32'hDEAD);
        exp_q.push_back(mdl[5]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL reg5_committed got=%h want=%h", bus.RsData, exp_v);
        end
    endtask

    task automatic test_mem2reg();
        idle();
        bus.Mem2Reg    = 1'b1;
        bus.Mem_r_data = 32'h1234;
        bus.ALUResult  = 32'h5678;
        bus.RdAddr     = 5'd7;
        bus.RegWrite   = 1'b1;
        bus.RsAddr     = 5'd7;
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h1234);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.WB_data !== exp_v) begin
            errors++;
            $display("FAIL wb_data_mem got=%h want=%h", bus.WB_data, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL mem_bypass got=%h want=%h", bus.RsData, exp_v);
        end
        bus.Mem2Reg = 1'b0;
        #1;
        checks++;
        if (bus.WB_data !== 32'h5678) begin
            errors++;
            $display("FAIL wb_data_alu got=%h want=%h", bus.WB_data, 32'h5678);
        end
        bus.Mem2Reg = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.RegWrite = 1'b0;
        mdl[7]  = 32'h1234;
        exp_cnt = exp_cnt + 32'd1;
        exp_q.push_back(mdl[7]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL mem_committed got=%h want=%h", bus.RsData, exp_v);
        end
    endtask

    task automatic test_rd_zero();
        idle();
        bus.RegWrite  = 1'b1;
        bus.RdAddr    = 5'd0;
        bus.ALUResult = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.RsData !== 32'h0 || bus.RtData !== 32'h0) begin
            errors++;
            $display("FAIL rd0_before rs=%h rt=%h want 0", bus.RsData, bus.RtData);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.RsData !== 32'h0 || bus.RtData !== 32'h0) begin
            errors++;
            $display("FAIL rd0_after rs=%h rt=%h want 0", bus.RsData, bus.RtData);
        end
        bus.RegWrite = 1'b0;
`ifdef WB_WRCOUNT_EN
        checks++;
        if (wr_count !== exp_cnt) begin
            errors++;
            $display("FAIL rd0_count got=%h want=%h", wr_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_dual_port();
        idle();
        write_reg(5'd3, 32'hA5A5);
        write_reg(5'd4, 32'h5A5A);
        bus.RsAddr = 5'd3;
        bus.RtAddr = 5'd4;
        exp_q.push_back(mdl[3]);
        exp_q.push_back(mdl[4]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL dual_rs got=%h want=%h", bus.RsData, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RtData !== exp_v) begin
            errors++;
            $display("FAIL dual_rt got=%h want=%h", bus.RtData, exp_v);
        end
        bus.RegWrite  = 1'b1;
        bus.RdAddr    = 5'd3;
        bus.ALUResult = 32'h1;
        bus.RsAddr    = 5'd3;
        bus.RtAddr    = 5'd3;
        #1;
        checks++;
        if (bus.RsData !== 32'h1 || bus.RtData !== 32'h1) begin
            errors++;
            $display("FAIL dual_bypass rs=%h rt=%h want 1", bus.RsData, bus.RtData);
        end
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [31:0]   d;
        idle();
        for (int k = 0; k < 12; k++) begin
            a = AW'($urandom_range(1, NR - 1));
            d = $urandom;
            write_reg(a, d);
        end
        for (int i = 1; i < NR; i++) begin
            bus.RsAddr = AW'(i);
            bus.RtAddr = AW'(NR - i);
            exp_q.push_back(mdl[i]);
            exp_q.push_back(mdl[NR - i]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.RsData !== exp_v) begin
                errors++;
                $display("FAIL b2b_rs addr=%0d got=%h want=%h", i, bus.RsData, exp_v);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.RtData !== exp_v) begin
                errors++;
                $display("FAIL b2b_rt addr=%0d got=%h want=%h", NR - i, bus.RtData, exp_v);
            end
        end
`ifdef WB_WRCOUNT_EN
        checks++;
        if (wr_count !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_count got=%h want=%h", wr_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset_run();
        idle();
        @(negedge clk);
        write_reg(5'd9, 32'h77);
        rst           = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.RdAddr    = 5'd9;
        bus.ALUResult = 32'h88;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RsAddr   = 5'd9;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL rerun_ready_drop got=%b want=0", bus.ready);
        end
        for (int i = 0; i < NR - 1; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 1; i < NR; i++) mdl[i] = INITV;
        exp_cnt = 32'h0;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL rerun_ready got=%b want=1", bus.ready);
        end
        exp_q.push_back(mdl[9]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.RsData !== exp_v) begin
            errors++;
            $display("FAIL rerun_reg9 got=%h want=%h", bus.RsData, exp_v);
        end
`ifdef WB_WRCOUNT_EN
        checks++;
        if (wr_count !== exp_cnt) begin
            errors++;
            $display("FAIL rerun_count got=%h want=%h", wr_count, exp_cnt);
        end
`endif
    endtask

`ifdef WB_WRCOUNT_EN
    task automatic test_wrcount_wrap();
        idle();
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wr_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        write_reg(5'd12, 32'hC0DE);
        checks++;
        if (wr_count !== exp_cnt) begin
            errors++;
            $display("FAIL count_max got=%h want=%h", wr_count, exp_cnt);
        end
        write_reg(5'd13, 32'hBEEF);
        checks++;
        if (wr_count !== exp_cnt) begin
            errors++;
            $display("FAIL count_wrap got=%h want=%h", wr_count, exp_cnt);
        end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_mem2reg();
        test_rd_zero();
        test_dual_port();
        test_back_to_back();
        test_reset_run();
`ifdef WB_WRCOUNT_EN
        test_wrcount_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
